rib_arb2: RTL and testbench

- Two-master to one-slave arbiter on the RIB bus.
- Master 0 is the instruction fetch port. Master 1 is the EXU load/store port (the LSU RIB master signals).
- Selects one requester per address phase and forwards its request to the shared slave port.
- Records the owner of each granted transaction in an in-order FIFO so that slave responses are routed back to the correct master.
- Sits between the core masters and the system bus/crossbar.

---
 rtl/rib_arb2.sv | 146 ++++++++++++++
 tb/tb_rib_arb2.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rib_arb2.sv
// Two-master to one-slave RIB arbiter with an in-order owner FIFO for response routing.
// Define RIB_ARB_RR_EN for round-robin arbitration; default is fixed priority (m1 over m0).
module rib_arb2 #(
    parameter int OUTST = 2,
    parameter int PTRW  = 1
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [31:0] i_m0_addr,
    input  logic        i_m0_wrcs,
    input  logic [3:0]  i_m0_mask,
    input  logic [31:0] i_m0_wdata,
    input  logic        i_m0_req,
    output logic        o_m0_gnt,
    output logic        o_m0_rsp,
    output logic [31:0] o_m0_rdata,
    input  logic        i_m0_rdy,
    input  logic [31:0] i_m1_addr,
    input  logic        i_m1_wrcs,
    input  logic [3:0]  i_m1_mask,
    input  logic [31:0] i_m1_wdata,
    input  logic        i_m1_req,
    output logic        o_m1_gnt,
    output logic        o_m1_rsp,
    output logic [31:0] o_m1_rdata,
    input  logic        i_m1_rdy,
    output logic [31:0] o_s_addr,
    output logic        o_s_wrcs,
    output logic [3:0]  o_s_mask,
    output logic [31:0] o_s_wdata,
    output logic        o_s_req,
    input  logic        i_s_gnt,
    input  logic        i_s_rsp,
    input  logic [31:0] i_s_rdata,
    output logic        o_s_rdy
);

    localparam logic [PTRW:0] CNT_FULL = (PTRW+1)'(OUTST);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t          state_reg, state_next;
    logic            owner_reg, owner_next;
    logic [OUTST-1:0] fifo_reg;
    logic [PTRW-1:0] wptr_reg, rptr_reg;
    logic [PTRW:0]   cnt_reg;

    logic win, sel, req_sel, full, empty, push, pop, head;

`ifdef RIB_ARB_RR_EN
    logic rr_reg;

    // rr_reg names the preferred master; it only matters when both request.
    always_comb begin
        win = (i_m0_req & i_m1_req) ? rr_reg : i_m1_req;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rr_reg <= 1'b0;
        end else if (push) begin
            rr_reg <= ~sel;
        end
    end
`else
    always_comb begin
        win = i_m1_req;
    end
`endif

    assign sel     = (state_reg == S_WAIT) ? owner_reg : win;
    assign req_sel = sel ? i_m1_req : i_m0_req;
    assign full    = (cnt_reg == CNT_FULL);
    assign empty   = (cnt_reg == '0);
    assign head    = fifo_reg[rptr_reg];

    assign o_s_req   = req_sel & ~full;
    assign o_s_addr  = sel ? i_m1_addr  : i_m0_addr;
    assign o_s_wrcs  = sel ? i_m1_wrcs  : i_m0_wrcs;
    assign o_s_mask  = sel ? i_m1_mask  : i_m0_mask;
    assign o_s_wdata = sel ? i_m1_wdata : i_m0_wdata;

    assign push = o_s_req & i_s_gnt;
    assign o_m0_gnt = push & ~sel;
    assign o_m1_gnt = push & sel;

    assign o_s_rdy    = ~empty & (head ? i_m1_rdy : i_m0_rdy);
    assign pop        = o_s_rdy & i_s_rsp;
    assign o_m0_rsp   = i_s_rsp & ~empty & ~head;
    assign o_m1_rsp   = i_s_rsp & ~empty & head;
    assign o_m0_rdata = i_s_rdata;
    assign o_m1_rdata = i_s_rdata;

    // WAIT locks the address mux onto the stalled owner until the slave accepts it.
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        case (state_reg)
            S_IDLE: begin
                if (o_s_req && !i_s_gnt) begin
                    state_next = S_WAIT;
                    owner_next = sel;
                end
            end
            S_WAIT: begin
                if (push || !req_sel) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg <= S_IDLE;
            owner_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            fifo_reg <= '0;
            wptr_reg <= '0;
            rptr_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            if (push) begin
                fifo_reg[wptr_reg] <= sel;
                wptr_reg           <= wptr_reg + 1'b1;
            end
            if (pop) begin
                rptr_reg <= rptr_reg + 1'b1;
            end
            if (push && !pop) begin
                cnt_reg <= cnt_reg + 1'b1;
            end else if (!push && pop) begin
                cnt_reg <= cnt_reg - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rib_arb2.sv
// Bench for rib_arb2: directed vector tables for the corner cases plus a
// randomized run checked against a queue-based model of the arbiter.
module tb_rib_arb2;
    localparam int OUTST = 2;
    localparam int PTRW  = 1;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic [31:0] i_m0_addr, i_m0_wdata, i_m1_addr, i_m1_wdata, i_s_rdata;
    logic        i_m0_wrcs, i_m1_wrcs;
    logic [3:0]  i_m0_mask, i_m1_mask;
    logic        i_m0_req, i_m1_req, i_m0_rdy, i_m1_rdy, i_s_gnt, i_s_rsp;
    logic        o_m0_gnt, o_m0_rsp, o_m1_gnt, o_m1_rsp, o_s_wrcs, o_s_req, o_s_rdy;
    logic [31:0] o_m0_rdata, o_m1_rdata, o_s_addr, o_s_wdata;
    logic [3:0]  o_s_mask;

    rib_arb2 #(.OUTST(OUTST), .PTRW(PTRW)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_m0_addr(i_m0_addr), .i_m0_wrcs(i_m0_wrcs), .i_m0_mask(i_m0_mask),
        .i_m0_wdata(i_m0_wdata), .i_m0_req(i_m0_req), .o_m0_gnt(o_m0_gnt),
        .o_m0_rsp(o_m0_rsp), .o_m0_rdata(o_m0_rdata), .i_m0_rdy(i_m0_rdy),
        .i_m1_addr(i_m1_addr), .i_m1_wrcs(i_m1_wrcs), .i_m1_mask(i_m1_mask),
        .i_m1_wdata(i_m1_wdata), .i_m1_req(i_m1_req), .o_m1_gnt(o_m1_gnt),
        .o_m1_rsp(o_m1_rsp), .o_m1_rdata(o_m1_rdata), .i_m1_rdy(i_m1_rdy),
        .o_s_addr(o_s_addr), .o_s_wrcs(o_s_wrcs), .o_s_mask(o_s_mask),
        .o_s_wdata(o_s_wdata), .o_s_req(o_s_req), .i_s_gnt(i_s_gnt),
        .i_s_rsp(i_s_rsp), .i_s_rdata(i_s_rdata), .o_s_rdy(o_s_rdy)
    );

    always #5 i_clk = ~i_clk;

    // in = {m0_req, m1_req, s_gnt, s_rsp, m0_rdy, m1_rdy}
    // ex = {s_req, m0_gnt, m1_gnt, m0_rsp, m1_rsp, s_rdy}
    typedef struct {
        logic [5:0]  in;
        logic [5:0]  ex;
        logic [31:0] addr;
    } vec_t;

    vec_t vq[$];
    int checks = 0;
    int failures = 0;

    function automatic vec_t mk(logic [5:0] in, logic [5:0] ex, logic [31:0] addr);
        vec_t v;
        v.in = in;
        v.ex = ex;
        v.addr = addr;
        return v;
    endfunction

    function automatic int pick(bit r0, bit r1, int pref);
`ifdef RIB_ARB_RR_EN
        if (r0 && r1) return pref;
`endif
        if (r1) return 1;
        if (r0) return 0;
        return -1;
    endfunction

    function automatic logic [5:0] outs();
        return {o_s_req, o_m0_gnt, o_m1_gnt, o_m0_rsp, o_m1_rsp, o_s_rdy};
    endfunction

    task automatic cmp(string name, int idx, logic [68:0] got, logic [68:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%h exp=%h", name, idx, got, exp);
        end
    endtask

    task automatic fixed_payload();
        i_m0_addr = 32'h0000_1000; i_m0_wrcs = 1'b0; i_m0_mask = 4'h3; i_m0_wdata = 32'hCAFE_0000;
        i_m1_addr = 32'h0000_0200; i_m1_wrcs = 1'b1; i_m1_mask = 4'hF; i_m1_wdata = 32'h1234_5678;
        i_s_rdata = 32'hDEAD_BEEF;
    endtask

    task automatic drive_in(logic [5:0] in);
        {i_m0_req, i_m1_req, i_s_gnt, i_s_rsp, i_m0_rdy, i_m1_rdy} = in;
    endtask

    task automatic check_vec(string name, int k, vec_t v);
        logic [68:0] pl_exp;
        cmp({name, ".ctl"}, k, {63'd0, outs()}, {63'd0, v.ex});
        if (v.ex[5]) begin
            pl_exp = (v.addr == 32'h200) ? {i_m1_addr, i_m1_wrcs, i_m1_mask, i_m1_wdata}
                                         : {i_m0_addr, i_m0_wrcs, i_m0_mask, i_m0_wdata};
            cmp({name, ".payload"}, k, {o_s_addr, o_s_wrcs, o_s_mask, o_s_wdata},
                {v.addr, pl_exp[36:0]});
        end
        cmp({name, ".rdata"}, k, {5'd0, o_m0_rdata, o_m1_rdata}, {5'd0, i_s_rdata, i_s_rdata});
    endtask

    task automatic run_vecs(string name);
        for (int k = 0; k < vq.size(); k++) begin
            @(posedge i_clk);
            #1 drive_in(vq[k].in);
            @(negedge i_clk);
            $display("%s[%0d] in=%b out=%b exp=%b", name, k, vq[k].in, outs(), vq[k].ex);
            check_vec(name, k, vq[k]);
        end
        vq.delete();
    endtask

    task automatic do_reset();
        i_rstn = 1'b0;
        drive_in(6'b000000);
        @(posedge i_clk);
        @(negedge i_clk);
        cmp("reset", 0, {63'd0, outs()}, 69'd0);
        @(posedge i_clk);
        #1 i_rstn = 1'b1;
    endtask

    initial begin
        int locked, pref, sel, head, g, pg;
        int oq[$];
        bit rq[2];
        bit rd[2];
        bit e_sreq, eg0, eg1, er0, er1, erdy;
        logic [68:0] pl_exp;

        fixed_payload();
        do_reset();

        // single access, contention, backpressure, stray response
        vq.push_back(mk(6'b000000, 6'b000000, 32'h0));
        vq.push_back(mk(6'b101011, 6'b110000, 32'h1000));
        vq.push_back(mk(6'b000011, 6'b000001, 32'h0));
        vq.push_back(mk(6'b000111, 6'b000101, 32'h0));
        vq.push_back(mk(6'b000111, 6'b000000, 32'h0));
        vq.push_back(mk(6'b111011, 6'b101000, 32'h200));
        vq.push_back(mk(6'b101011, 6'b110001, 32'h1000));
        vq.push_back(mk(6'b000110, 6'b000010, 32'h0));
        vq.push_back(mk(6'b000111, 6'b000011, 32'h0));
        vq.push_back(mk(6'b000111, 6'b000101, 32'h0));
        vq.push_back(mk(6'b000000, 6'b000000, 32'h0));
        run_vecs("table");

        // stall in WAIT: address stays on m0 while m1 waits
        vq.push_back(mk(6'b100000, 6'b100000, 32'h1000));
        vq.push_back(mk(6'b110000, 6'b100000, 32'h1000));
        vq.push_back(mk(6'b110000, 6'b100000, 32'h1000));
        vq.push_back(mk(6'b111000, 6'b110000, 32'h1000));
        vq.push_back(mk(6'b011000, 6'b101000, 32'h200));
        vq.push_back(mk(6'b000111, 6'b000101, 32'h0));
        vq.push_back(mk(6'b000111, 6'b000011, 32'h0));
        run_vecs("stall");

        // full FIFO, then push and pop in the same cycle
        vq.push_back(mk(6'b101000, 6'b110000, 32'h1000));
        vq.push_back(mk(6'b101000, 6'b110000, 32'h1000));
        vq.push_back(mk(6'b011000, 6'b000000, 32'h0));
        vq.push_back(mk(6'b011111, 6'b000101, 32'h0));
        vq.push_back(mk(6'b011111, 6'b101101, 32'h200));
        vq.push_back(mk(6'b101000, 6'b110000, 32'h1000));
        vq.push_back(mk(6'b101001, 6'b000001, 32'h0));
        vq.push_back(mk(6'b000111, 6'b000011, 32'h0));
        vq.push_back(mk(6'b000111, 6'b000101, 32'h0));
        vq.push_back(mk(6'b000111, 6'b000000, 32'h0));
        run_vecs("full");

        // reset while a response is outstanding
        vq.push_back(mk(6'b101000, 6'b110000, 32'h1000));
        vq.push_back(mk(6'b000011, 6'b000001, 32'h0));
        run_vecs("rstmid");
        #2 i_rstn = 1'b0;
        #1 cmp("rstmid.inreset", 0, {63'd0, outs()}, 69'd0);
        @(posedge i_clk);
        #1 i_rstn = 1'b1;
        vq.push_back(mk(6'b000111, 6'b000000, 32'h0));
        run_vecs("rstmid.after");

        // both masters requesting continuously
        do_reset();
        pg = 0;
        for (int k = 0; k < 6; k++) begin
`ifdef RIB_ARB_RR_EN
            g = k % 2;
`else
            g = 1;
`endif
            vq.push_back(mk(6'b111111,
                {1'b1, g == 0, g == 1, k > 0 && pg == 0, k > 0 && pg == 1, k > 0},
                (g == 1) ? 32'h200 : 32'h1000));
            pg = g;
        end
        run_vecs("both");

        // randomized run against the reference model
        do_reset();
        locked = -1;
        pref = 0;
        eg0 = 1'b0;
        eg1 = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge i_clk);
            #1;
            if (!i_m0_req || eg0) begin
                i_m0_req = 1'($urandom_range(0, 1));
                i_m0_addr = $urandom; i_m0_wrcs = 1'($urandom); i_m0_mask = 4'($urandom); i_m0_wdata = $urandom;
            end
            if (!i_m1_req || eg1) begin
                i_m1_req = 1'($urandom_range(0, 1));
                i_m1_addr = $urandom; i_m1_wrcs = 1'($urandom); i_m1_mask = 4'($urandom); i_m1_wdata = $urandom;
            end
            i_s_gnt  = ($urandom_range(0, 2) != 0);
            i_s_rsp  = ($urandom_range(0, 1) != 0);
            i_m0_rdy = ($urandom_range(0, 3) != 0);
            i_m1_rdy = ($urandom_range(0, 3) != 0);
            i_s_rdata = $urandom;
            @(negedge i_clk);

            rq[0] = i_m0_req; rq[1] = i_m1_req;
            rd[0] = i_m0_rdy; rd[1] = i_m1_rdy;
            sel = (locked >= 0) ? locked : pick(rq[0], rq[1], pref);
            e_sreq = (sel >= 0) && rq[sel] && (oq.size() < OUTST);
            eg0 = i_s_gnt && e_sreq && sel == 0;
            eg1 = i_s_gnt && e_sreq && sel == 1;
            head = (oq.size() > 0) ? oq[0] : -1;
            er0 = i_s_rsp && head == 0;
            er1 = i_s_rsp && head == 1;
            erdy = (head >= 0) && rd[head];

            cmp("rand.ctl", cyc, {63'd0, outs()}, {63'd0, e_sreq, eg0, eg1, er0, er1, erdy});
            if (e_sreq) begin
                pl_exp = (sel == 1) ? {i_m1_addr, i_m1_wrcs, i_m1_mask, i_m1_wdata}
                                    : {i_m0_addr, i_m0_wrcs, i_m0_mask, i_m0_wdata};
                cmp("rand.payload", cyc, {o_s_addr, o_s_wrcs, o_s_mask, o_s_wdata}, pl_exp);
            end
            cmp("rand.rdata", cyc, {5'd0, o_m0_rdata, o_m1_rdata}, {5'd0, i_s_rdata, i_s_rdata});

            if (erdy && i_s_rsp) void'(oq.pop_front());
            if (e_sreq && i_s_gnt) begin
                $display("rand[%0d] grant m%0d addr=%h", cyc, sel, o_s_addr);
                oq.push_back(sel);
                locked = -1;
                pref = 1 - sel;
            end else if (e_sreq) begin
                locked = sel;
            end else begin
                locked = -1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
